// File: rtl/keyboard_decoder_pkg.sv
// Shared types and constants for the PS/2 Set-2 keyboard decoder:
// FSM states, scancodes, key bit indices and the scancode-to-key mapping.
package kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0,
    ST_SKIP_E1
  } kbd_state_t;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_BOMB  = 4;
  localparam int NUM_KEYS  = 5;

  // Pause (E1 14 77 E1 F0 14 F0 77) has 7 bytes after the leading E1.
  localparam logic [2:0] E1_SKIP_LEN = 3'd7;

  typedef struct packed {
    logic       hit;
    logic       p2;
    logic [2:0] idx;
  } key_map_t;

  function automatic logic is_ignored(input logic [7:0] code);
    return (code == SC_BAT_OK) || (code == SC_ACK) || (code == SC_RESEND) ||
           (code == SC_ERR0) || (code == SC_ERR1);
  endfunction

  function automatic key_map_t map_key(input logic [7:0] code, input logic ext);
    key_map_t m;
    m = '0;
    if (!ext) begin
      case (code)
        SC_W:     m = '{hit: 1'b1, p2: 1'b0, idx: 3'(KEY_UP)};
        SC_S:     m = '{hit: 1'b1, p2: 1'b0, idx: 3'(KEY_DOWN)};
        SC_A:     m = '{hit: 1'b1, p2: 1'b0, idx: 3'(KEY_LEFT)};
        SC_D:     m = '{hit: 1'b1, p2: 1'b0, idx: 3'(KEY_RIGHT)};
        SC_SPACE: m = '{hit: 1'b1, p2: 1'b0, idx: 3'(KEY_BOMB)};
        SC_ENTER: m = '{hit: 1'b1, p2: 1'b1, idx: 3'(KEY_BOMB)};
        default:  m = '0;
      endcase
    end else begin
      case (code)
        SC_UP:    m = '{hit: 1'b1, p2: 1'b1, idx: 3'(KEY_UP)};
        SC_DOWN:  m = '{hit: 1'b1, p2: 1'b1, idx: 3'(KEY_DOWN)};
        SC_LEFT:  m = '{hit: 1'b1, p2: 1'b1, idx: 3'(KEY_LEFT)};
        SC_RIGHT: m = '{hit: 1'b1, p2: 1'b1, idx: 3'(KEY_RIGHT)};
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/keyboard_decoder_if.sv
// Byte input and decoded key-state output bundle of the keyboard decoder.
interface keyboard_decoder_if;
  import kbd_pkg::*;

  logic [7:0]          data_in;
  logic                data_valide;
  logic [NUM_KEYS-1:0] p1_keys;
  logic [NUM_KEYS-1:0] p2_keys;
  logic                key_event;
  logic [7:0]          key_code;
  logic                key_ext;
  logic                key_break;
  logic                esc_pulse;

  modport master (
    output data_in, data_valide,
    input  p1_keys, p2_keys, key_event, key_code, key_ext, key_break, esc_pulse
  );

  modport slave (
    input  data_in, data_valide,
    output p1_keys, p2_keys, key_event, key_code, key_ext, key_break, esc_pulse
  );
endinterface

// File: rtl/ps2_strobe_sync.sv
// Brings the PS/2 byte strobe and data into clk: 2-flop sync on both,
// plus a third strobe flop so exactly one accept pulse is made per byte.
module ps2_strobe_sync (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_strobe,
  input  logic [7:0] i_data,
  output logic       o_accept,
  output logic [7:0] o_data
);
  logic       r_stb_meta, r_stb_sync, r_stb_prev;
  logic [7:0] r_data_meta, r_data_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stb_meta  <= 1'b0;
      r_stb_sync  <= 1'b0;
      r_stb_prev  <= 1'b0;
      r_data_meta <= '0;
      r_data_sync <= '0;
    end else begin
      r_stb_meta  <= i_strobe;
      r_stb_sync  <= r_stb_meta;
      r_stb_prev  <= r_stb_sync;
      r_data_meta <= i_data;
      r_data_sync <= r_data_meta;
    end
  end

  // Data is stable for the whole strobe, so its synced copy is settled when the edge is seen.
  assign o_accept = r_stb_sync & ~r_stb_prev;
  assign o_data   = r_data_sync;
endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 Set-2 prefix parser (E0/F0/E1) producing held-key bitmaps for two
// players and a one-cycle event report per completed make/break code.
module keyboard_decoder
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input logic               clk,
  input logic               reset_n,
  keyboard_decoder_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic                w_accept;
  logic [7:0]          w_byte;
  kbd_state_t          r_state, w_state_next;
  logic [2:0]          r_skip, w_skip_next;
  logic [TW-1:0]       r_tmo, w_tmo_next;
  logic                w_emit, w_ext, w_brk, w_esc;
  key_map_t            w_map;
  logic [NUM_KEYS-1:0] w_p1_next, w_p2_next;
  logic [NUM_KEYS-1:0] r_p1, r_p2;
  logic                r_event, r_ext, r_brk, r_esc;
  logic [7:0]          r_code;

  ps2_strobe_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_strobe (bus.data_valide),
    .i_data   (bus.data_in),
    .o_accept (w_accept),
    .o_data   (w_byte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_skip  <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_next;
      r_skip  <= w_skip_next;
      r_tmo   <= w_tmo_next;
    end
  end

  // An accepted byte takes priority over a timeout expiring in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_skip_next  = r_skip;
    w_tmo_next   = r_tmo;
    if (w_accept) begin
      w_tmo_next = '0;
      case (r_state)
        ST_IDLE: begin
          if (w_byte == SC_E0) w_state_next = ST_GOT_E0;
          else if (w_byte == SC_F0) w_state_next = ST_GOT_F0;
          else if (w_byte == SC_E1) begin
            w_state_next = ST_SKIP_E1;
            w_skip_next  = E1_SKIP_LEN;
          end
        end
        ST_GOT_E0: begin
          if (w_byte == SC_F0) w_state_next = ST_GOT_E0F0;
          else if (w_byte != SC_E0) w_state_next = ST_IDLE;
        end
        ST_GOT_F0:   if (w_byte != SC_F0) w_state_next = ST_IDLE;
        ST_GOT_E0F0: w_state_next = ST_IDLE;
        ST_SKIP_E1: begin
          w_skip_next = r_skip - 3'd1;
          if (r_skip <= 3'd1) begin
            w_state_next = ST_IDLE;
            w_skip_next  = '0;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end else if (r_state == ST_IDLE) begin
      w_tmo_next = '0;
    end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
      w_state_next = ST_IDLE;
      w_tmo_next   = '0;
      w_skip_next  = '0;
    end else begin
      w_tmo_next = r_tmo + 1'b1;
    end
  end

  always_comb begin
    w_emit = 1'b0;
    w_ext  = 1'b0;
    w_brk  = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE:     w_emit = (w_byte != SC_E0) && (w_byte != SC_F0) &&
                              (w_byte != SC_E1) && !is_ignored(w_byte);
        ST_GOT_E0: begin
          w_emit = (w_byte != SC_F0) && (w_byte != SC_E0);
          w_ext  = 1'b1;
        end
        ST_GOT_F0: begin
          w_emit = (w_byte != SC_F0);
          w_brk  = 1'b1;
        end
        ST_GOT_E0F0: begin
          w_emit = 1'b1;
          w_ext  = 1'b1;
          w_brk  = 1'b1;
        end
        default: w_emit = 1'b0;
      endcase
    end
    w_map = map_key(w_byte, w_ext);
    w_esc = w_emit && !w_brk && !w_ext && (w_byte == SC_ESC);
    w_p1_next = r_p1;
    w_p2_next = r_p2;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (w_emit && w_map.hit && (w_map.idx == 3'(k))) begin
        if (w_map.p2) w_p2_next[k] = ~w_brk;
        else          w_p1_next[k] = ~w_brk;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p1    <= '0;
      r_p2    <= '0;
      r_event <= 1'b0;
      r_esc   <= 1'b0;
      r_code  <= '0;
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
    end else begin
      r_p1    <= w_p1_next;
      r_p2    <= w_p2_next;
      r_event <= w_emit;
      r_esc   <= w_esc;
      if (w_emit) begin
        r_code <= w_byte;
        r_ext  <= w_ext;
        r_brk  <= w_brk;
      end
    end
  end

  assign bus.p1_keys   = r_p1;
  assign bus.p2_keys   = r_p2;
  assign bus.key_event = r_event;
  assign bus.key_code  = r_code;
  assign bus.key_ext   = r_ext;
  assign bus.key_break = r_brk;
  assign bus.esc_pulse = r_esc;
endmodule

// File: tb/tb_keyboard_decoder.sv
// Scoreboard bench for keyboard_decoder: expected events are queued as bytes
// are sent and compared whenever the decoder reports an event.
module tb_keyboard_decoder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_events = 0;
  logic prev_evt = 1'b0;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [4:0] p1;
    logic [4:0] p2;
    logic       esc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  keyboard_decoder_if kif ();

  keyboard_decoder #(.TIMEOUT_CYCLES(100)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (kif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] code, input logic ext, input logic brk,
                      input logic [4:0] p1, input logic [4:0] p2, input logic esc);
    exp_t e;
    e.code = code; e.ext = ext; e.brk = brk; e.p1 = p1; e.p2 = p2; e.esc = esc;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    kif.data_in = b;
    kif.data_valide = 1'b1;
    repeat (4) @(negedge clk);
    kif.data_valide = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_p1"}, 32'(kif.p1_keys), 0);
    chk({tag, "_p2"}, 32'(kif.p2_keys), 0);
    chk({tag, "_evt"}, 32'(kif.key_event), 0);
    chk({tag, "_code"}, 32'(kif.key_code), 0);
    chk({tag, "_ext"}, 32'(kif.key_ext), 0);
    chk({tag, "_brk"}, 32'(kif.key_break), 0);
    chk({tag, "_esc"}, 32'(kif.esc_pulse), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (kif.key_event) begin
        n_events++;
        chk("evt_width", 32'(prev_evt), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_evt", 32'(kif.key_code), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          $display("event code=%02h ext=%0b brk=%0b p1=%05b p2=%05b esc=%0b",
                   kif.key_code, kif.key_ext, kif.key_break, kif.p1_keys, kif.p2_keys, kif.esc_pulse);
          chk("ev_code", 32'(kif.key_code), 32'(mon_e.code));
          chk("ev_ext", 32'(kif.key_ext), 32'(mon_e.ext));
          chk("ev_brk", 32'(kif.key_break), 32'(mon_e.brk));
          chk("ev_p1", 32'(kif.p1_keys), 32'(mon_e.p1));
          chk("ev_p2", 32'(kif.p2_keys), 32'(mon_e.p2));
          chk("ev_esc", 32'(kif.esc_pulse), 32'(mon_e.esc));
        end
      end else if (kif.esc_pulse) begin
        chk("esc_without_evt", 32'(kif.esc_pulse), 0);
      end
      prev_evt = kif.key_event;
    end else begin
      prev_evt = 1'b0;
    end
  end

  initial begin
    int ev0;
    kif.data_in = 8'h00;
    kif.data_valide = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // W make then break
    push(8'h1D, 0, 0, 5'b00001, 5'b00000, 0);
    send_byte(8'h1D);
    push(8'h1D, 0, 1, 5'b00000, 5'b00000, 0);
    send_byte(8'hF0);
    send_byte(8'h1D);

    // Extended arrow make/break, exactly two events
    ev0 = n_events;
    push(8'h75, 1, 0, 5'b00000, 5'b00001, 0);
    send_byte(8'hE0);
    send_byte(8'h75);
    push(8'h75, 1, 1, 5'b00000, 5'b00000, 0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    chk("ext_evt_count", 32'(n_events - ev0), 2);

    // Pause sequence skipped, then Space
    ev0 = n_events;
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    chk("pause_no_evt", 32'(n_events - ev0), 0);
    push(8'h29, 0, 0, 5'b10000, 5'b00000, 0);
    send_byte(8'h29);
    push(8'h29, 0, 1, 5'b00000, 5'b00000, 0);
    send_byte(8'hF0);
    send_byte(8'h29);

    // Prefix times out: 1D is a plain make
    send_byte(8'hE0);
    repeat (150) @(negedge clk);
    push(8'h1D, 0, 0, 5'b00001, 5'b00000, 0);
    send_byte(8'h1D);
    chk("tmo_ext", 32'(kif.key_ext), 0);
    push(8'h1D, 0, 1, 5'b00000, 5'b00000, 0);
    send_byte(8'hF0);
    send_byte(8'h1D);

    // Prefix within timeout stays extended
    send_byte(8'hE0);
    repeat (60) @(negedge clk);
    push(8'h75, 1, 0, 5'b00000, 5'b00001, 0);
    send_byte(8'h75);
    push(8'h75, 1, 1, 5'b00000, 5'b00000, 0);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);

    // Enter is player-2 bomb without E0
    push(8'h5A, 0, 0, 5'b00000, 5'b10000, 0);
    send_byte(8'h5A);

    // Escape latency: event visible after edge 3, gone after edge 4
    push(8'h76, 0, 0, 5'b00000, 5'b10000, 1);
    @(negedge clk);
    kif.data_in = 8'h76;
    kif.data_valide = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("esc_edge2_evt", 32'(kif.key_event), 0);
    @(posedge clk); #1;
    chk("esc_edge3_evt", 32'(kif.key_event), 1);
    chk("esc_edge3_esc", 32'(kif.esc_pulse), 1);
    @(posedge clk); #1;
    chk("esc_edge4_evt", 32'(kif.key_event), 0);
    chk("esc_edge4_esc", 32'(kif.esc_pulse), 0);
    @(negedge clk);
    kif.data_valide = 1'b0;
    repeat (6) @(negedge clk);

    // Ignored bytes, and last code holds
    ev0 = n_events;
    send_byte(8'hAA);
    send_byte(8'hFA);
    chk("ignore_no_evt", 32'(n_events - ev0), 0);
    chk("code_hold", 32'(kif.key_code), 32'h76);

    // Reset mid-prefix
    push(8'h1D, 0, 0, 5'b00001, 5'b10000, 0);
    send_byte(8'h1D);
    send_byte(8'hF0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("midreset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    push(8'h23, 0, 0, 5'b01000, 5'b00000, 0);
    send_byte(8'h23);

    repeat (20) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
